// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol sequencer: START/STOP detection, address match, ACK generation
// and a byte-wide register port with auto-incrementing pointer. Optional macro: I2C_SLAVE_GENERAL_CALL_EN.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_LOAD, RD_BYTE, RD_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d, scl, sda;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  // Bus idles high, so the synchronisers reset to 1 to avoid a false START after reset.
  always_ff @(posedge clk) begin
    if (Rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value; blocking would collapse the chain.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl;
      sda_d    <= sda;
    end
  end

  assign scl       = scl_sync[SYNC_STAGES-1];
  assign sda       = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  assign start_det = scl & scl_d & sda_d & ~sda;
  assign stop_det  = scl & scl_d & ~sda_d & sda;

  state_t     state, state_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt, tx, tx_nxt, pointer, pointer_nxt;
  logic [7:0] reg_addr_nxt, reg_wdata_nxt;
  logic       sda_oe_nxt, busy_nxt, reg_we_nxt, reg_re_nxt;
  logic       ptr_load, ptr_load_nxt, gc, gc_nxt, re_d;
  logic       gc_hit, addr_hit;
  logic [7:0] rx_byte;

  assign rx_byte = {shift[6:0], sda};

`ifdef I2C_SLAVE_GENERAL_CALL_EN
  // General call is write-only: 0x01 (R/W=1) must not match.
  assign gc_hit = (shift == 8'h00);
`else
  assign gc_hit = 1'b0;
`endif
  assign addr_hit = (shift[7:1] == SLV_ADDR) || gc_hit;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    tx_nxt        = tx;
    pointer_nxt   = pointer;
    sda_oe_nxt    = sda_oe;
    busy_nxt      = busy;
    reg_we_nxt    = 1'b0;
    reg_re_nxt    = 1'b0;
    reg_addr_nxt  = reg_addr;
    reg_wdata_nxt = reg_wdata;
    ptr_load_nxt  = ptr_load;
    gc_nxt        = gc;

    // Pointer advances the clk after a write strobe; general-call writes leave it alone.
    if (reg_we && !gc) pointer_nxt = pointer + 8'd1;

    if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
    end else if (stop_det) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (bit_cnt == 4'd8) begin
            if (!addr_hit) begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
            end else if (scl_fall) begin
              state_nxt  = ADDR_ACK;
              sda_oe_nxt = 1'b1;
              busy_nxt   = 1'b1;
              gc_nxt     = gc_hit;
            end
          end else if (scl_rise) begin
            shift_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
        ADDR_ACK: begin
          if (shift[0]) begin
            if (scl_rise) begin
              reg_re_nxt   = 1'b1;
              reg_addr_nxt = pointer;
              state_nxt    = RD_LOAD;
            end
          end else if (scl_fall) begin
            sda_oe_nxt   = 1'b0;
            bit_cnt_nxt  = 4'd0;
            ptr_load_nxt = 1'b1;
            state_nxt    = WR_BYTE;
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state_nxt = WR_ACK;
              if (ptr_load && !gc) begin
                pointer_nxt  = rx_byte;
                ptr_load_nxt = 1'b0;
              end else begin
                reg_we_nxt    = 1'b1;
                reg_addr_nxt  = gc ? 8'hFF : pointer;
                reg_wdata_nxt = rx_byte;
              end
            end
          end
        end
        WR_ACK: begin
          // First falling edge drives the ACK, the second (9th) releases it.
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = 4'd0;
              state_nxt   = WR_BYTE;
            end
          end
        end
        RD_LOAD: begin
          if (re_d) begin
            tx_nxt      = reg_rdata;
            pointer_nxt = pointer + 8'd1;
          end
          if (scl_fall) begin
            sda_oe_nxt  = ~tx[7];
            bit_cnt_nxt = 4'd1;
            state_nxt   = RD_BYTE;
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt = 1'b0;
              state_nxt  = RD_ACK;
            end else begin
              sda_oe_nxt  = ~tx[6];
              tx_nxt      = {tx[6:0], 1'b0};
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda) begin
              reg_re_nxt   = 1'b1;
              reg_addr_nxt = pointer;
              state_nxt    = RD_LOAD;
            end else begin
              busy_nxt   = 1'b0;
              sda_oe_nxt = 1'b0;
              state_nxt  = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      tx        <= 8'h00;
      pointer   <= 8'h00;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      ptr_load  <= 1'b0;
      gc        <= 1'b0;
      re_d      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      tx        <= tx_nxt;
      pointer   <= pointer_nxt;
      sda_oe    <= sda_oe_nxt;
      busy      <= busy_nxt;
      reg_we    <= reg_we_nxt;
      reg_re    <= reg_re_nxt;
      reg_addr  <= reg_addr_nxt;
      reg_wdata <= reg_wdata_nxt;
      ptr_load  <= ptr_load_nxt;
      gc        <= gc_nxt;
      re_d      <= reg_re;
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: a bit-banged I2C master on a wired-AND SDA,
// a registered register-file model, and strobe logs compared against hand-computed values.
module tb_i2c_slave_ctrl;

  localparam int QC = 5;  // clk cycles per quarter SCL period (SCL = clk/20)

  logic       clk = 1'b0;
  logic       Rst;
  logic       m_scl, m_sda, sda_bus;
  logic       sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  logic [7:0]  mem [256];
  logic [15:0] we_log [$];
  logic [7:0]  re_log [$];
  int          oe_cnt  = 0;
  int          overlap = 0;
  int          total   = 0;
  int          bad     = 0;

  always #5 clk = ~clk;

  assign sda_bus = m_sda & ~sda_oe;

  i2c_slave_ctrl dut (
    .clk       (clk),
    .Rst       (Rst),
    .scl_i     (m_scl),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  // Register file: read data valid the clk after reg_re.
  always @(posedge clk) if (reg_re) reg_rdata <= mem[reg_addr];

  always @(negedge clk) begin
    if (reg_we) we_log.push_back({reg_addr, reg_wdata});
    if (reg_re) re_log.push_back(reg_addr);
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (reg_we && reg_re) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quarter();
    repeat (QC) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic r, output logic oe);
    m_sda = b;
    quarter();
    m_scl = 1'b1;
    quarter();
    r  = sda_bus;
    oe = sda_oe;
    quarter();
    m_scl = 1'b0;
    quarter();
  endtask

  task automatic start_c();
    m_sda = 1'b0;
    quarter();
    m_scl = 1'b0;
    quarter();
  endtask

  task automatic rstart_c();
    m_sda = 1'b1;
    quarter();
    m_scl = 1'b1;
    quarter();
    m_sda = 1'b0;
    quarter();
    m_scl = 1'b0;
    quarter();
  endtask

  task automatic stop_c();
    m_sda = 1'b0;
    quarter();
    m_scl = 1'b1;
    quarter();
    m_sda = 1'b1;
    quarter();
  endtask

  // ack = sda_oe seen during the high phase of the 9th clock.
  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r, oe;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r, oe);
    clock_bit(1'b1, r, oe);
    ack = oe;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r, oe;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r, oe);
      d[i] = r;
    end
    clock_bit(~mack, r, oe);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         wb, rb, ob;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h5A;
    mem[8'h21] = 8'hC3;
    mem[8'h00] = 8'h96;
    reg_rdata  = 8'h00;
    m_scl = 1'b1;
    m_sda = 1'b1;
    Rst   = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_reg_we", reg_we, 1'b0);
    check("rst_reg_re", reg_re, 1'b0);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    Rst = 1'b0;
    quarter();

    // Write: pointer 0x10, data A5, 3C
    wb = we_log.size(); rb = re_log.size();
    start_c();
    send_byte(8'hA0, ack); check("wr_ack_addr", ack, 1'b1);
    send_byte(8'h10, ack); check("wr_ack_ptr", ack, 1'b1);
    send_byte(8'hA5, ack); check("wr_ack_d0", ack, 1'b1);
    send_byte(8'h3C, ack); check("wr_ack_d1", ack, 1'b1);
    check("wr_busy_before_stop", busy, 1'b1);
    stop_c();
    quarter();
    check("wr_busy_after_stop", busy, 1'b0);
    check("wr_we_count", we_log.size() - wb, 2);
    check("wr_we0", we_log[wb], 16'h10A5);
    check("wr_we1", we_log[wb+1], 16'h113C);
    check("wr_re_count", re_log.size() - rb, 0);

    // Read with repeated START
    wb = we_log.size(); rb = re_log.size();
    start_c();
    send_byte(8'hA0, ack); check("rd_ack_waddr", ack, 1'b1);
    send_byte(8'h20, ack); check("rd_ack_ptr", ack, 1'b1);
    rstart_c();
    send_byte(8'hA1, ack); check("rd_ack_raddr", ack, 1'b1);
    read_byte(1'b1, d); check("rd_data0", d, 8'h5A);
    read_byte(1'b0, d); check("rd_data1", d, 8'hC3);
    check("rd_busy_after_nack", busy, 1'b0);
    check("rd_oe_after_nack", sda_oe, 1'b0);
    stop_c();
    quarter();
    check("rd_re_count", re_log.size() - rb, 2);
    check("rd_re0", re_log[rb], 8'h20);
    check("rd_re1", re_log[rb+1], 8'h21);
    check("rd_we_count", we_log.size() - wb, 0);

    // Address mismatch
    wb = we_log.size(); rb = re_log.size(); ob = oe_cnt;
    start_c();
    send_byte(8'hA2, ack); check("mm_ack", ack, 1'b0);
    send_byte(8'h5A, ack);
    check("mm_busy", busy, 1'b0);
    stop_c();
    quarter();
    check("mm_oe_never", oe_cnt - ob, 0);
    check("mm_we_count", we_log.size() - wb, 0);
    check("mm_re_count", re_log.size() - rb, 0);

    // Pointer wrap FF -> 00
    wb = we_log.size();
    start_c();
    send_byte(8'hA0, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack); check("wrap_ack0", ack, 1'b1);
    send_byte(8'h22, ack); check("wrap_ack1", ack, 1'b1);
    stop_c();
    quarter();
    check("wrap_we_count", we_log.size() - wb, 2);
    check("wrap_we0", we_log[wb], 16'hFF11);
    check("wrap_we1", we_log[wb+1], 16'h0022);

    // STOP after 4 bits of a data byte
    wb = we_log.size();
    start_c();
    send_byte(8'hA0, ack);
    send_byte(8'h30, ack);
    send_byte(8'h44, ack);
    begin
      logic r, oe;
      clock_bit(1'b1, r, oe);
      clock_bit(1'b0, r, oe);
      clock_bit(1'b1, r, oe);
      clock_bit(1'b1, r, oe);
    end
    stop_c();
    quarter();
    check("abort_we_count", we_log.size() - wb, 1);
    check("abort_we0", we_log[wb], 16'h3044);
    check("abort_busy", busy, 1'b0);

    // Reset during RD_BYTE (mem[0x40]=0, so the first bit pulls SDA low)
    start_c();
    send_byte(8'hA0, ack);
    send_byte(8'h40, ack);
    rstart_c();
    send_byte(8'hA1, ack);
    check("rrst_pre_oe", sda_oe, 1'b1);
    check("rrst_pre_busy", busy, 1'b1);
    Rst = 1'b1;
    @(posedge clk);
    #1;
    check("rrst_sda_oe", sda_oe, 1'b0);
    check("rrst_busy", busy, 1'b0);
    check("rrst_reg_addr", reg_addr, 8'h00);
    check("rrst_reg_wdata", reg_wdata, 8'h00);
    check("rrst_strobes", {reg_we, reg_re}, 2'b00);
    m_scl = 1'b1;
    m_sda = 1'b1;
    repeat (4) @(negedge clk);
    Rst = 1'b0;
    quarter();

    // General call
    wb = we_log.size();
    start_c();
    send_byte(8'h00, ack);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    check("gc_ack_addr", ack, 1'b1);
    send_byte(8'h77, ack); check("gc_ack_data", ack, 1'b1);
    stop_c();
    quarter();
    check("gc_we_count", we_log.size() - wb, 1);
    check("gc_we0", we_log[wb], 16'hFF77);
`else
    check("gc_no_ack", ack, 1'b0);
    send_byte(8'h77, ack);
    stop_c();
    quarter();
    check("gc_we_count", we_log.size() - wb, 0);
    check("gc_busy", busy, 1'b0);
`endif

    // Read from pointer after reset: pointer must be 0x00
    rb = re_log.size();
    start_c();
    send_byte(8'hA1, ack); check("p0_ack", ack, 1'b1);
    read_byte(1'b0, d); check("p0_data", d, 8'h96);
    stop_c();
    quarter();
    check("p0_re_count", re_log.size() - rb, 1);
    check("p0_re0", re_log[rb], 8'h00);
    check("no_we_re_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
